// File: rtl/despread_seq.sv
// Chip-rate I/Q despreader with per-symbol dump and SEARCH/VERIFY/LOCK acquisition FSM.
// Optional macro DESPREAD_SAT_EN: saturating accumulators instead of two's-complement wrap.
module despread_seq #(
  parameter int CHIPS_PER_SYM = 16,
  parameter int SUM_W         = 10,
  parameter int TH            = 8,
  parameter int LOCK_CNT      = 4,
  parameter int MISS_CNT      = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    chip_vld,
  input  logic signed [3:0]       rx_I,
  input  logic signed [3:0]       rx_Q,
  input  logic                    pn,
  output logic signed [SUM_W-1:0] sum_I,
  output logic signed [SUM_W-1:0] sum_Q,
  output logic                    result_ok,
  output logic                    flag,
  output logic                    slip
);

  localparam int CNT_W  = $clog2(CHIPS_PER_SYM);
  localparam int HIT_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(MISS_CNT + 1);

`ifdef DESPREAD_SAT_EN
  localparam logic signed [SUM_W:0] SAT_MAX = {2'b00, {(SUM_W-1){1'b1}}};
  localparam logic signed [SUM_W:0] SAT_MIN = {2'b11, {(SUM_W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCK} state_t;

  state_t                  state, state_nxt;
  logic [HIT_W-1:0]        hit_cnt, hit_nxt;
  logic [MISS_W-1:0]       miss_cnt, miss_nxt;
  logic                    slip_nxt;
  logic signed [SUM_W-1:0] acc_I, acc_Q, acc_I_nxt, acc_Q_nxt;
  logic signed [SUM_W-1:0] s_I, s_Q;
  logic [CNT_W-1:0]        chip_cnt;
  logic                    dump_d, rdy_d, eval, is_hit;
  logic [SUM_W:0]          metric;

  function automatic logic signed [SUM_W-1:0] acc_step(
    input logic signed [SUM_W-1:0] acc,
    input logic signed [3:0]       rx,
    input logic                    neg
  );
    logic signed [SUM_W-1:0] term;
`ifdef DESPREAD_SAT_EN
    logic signed [SUM_W:0] wide;
`endif
    term = {{(SUM_W-4){rx[3]}}, rx};
    if (neg) term = -term;
`ifdef DESPREAD_SAT_EN
    wide = {acc[SUM_W-1], acc} + {term[SUM_W-1], term};
    if (wide > SAT_MAX)      return SAT_MAX[SUM_W-1:0];
    else if (wide < SAT_MIN) return SAT_MIN[SUM_W-1:0];
    else                     return wide[SUM_W-1:0];
`else
    return acc + term;
`endif
  endfunction

  // Magnitude needs one extra bit so the most negative sum maps to +2^(SUM_W-1).
  function automatic logic [SUM_W:0] mag(input logic signed [SUM_W-1:0] v);
    logic [SUM_W:0] ext;
    ext = {v[SUM_W-1], v};
    return v[SUM_W-1] ? ((SUM_W+1)'(0) - ext) : ext;
  endfunction

  assign acc_I_nxt = acc_step(acc_I, rx_I, pn);
  assign acc_Q_nxt = acc_step(acc_Q, rx_Q, pn);
  assign metric    = mag(s_I) + mag(s_Q);
  assign is_hit    = (metric >= (SUM_W+1)'(TH));
  assign eval      = dump_d & en;

  always_comb begin
    state_nxt = state;
    hit_nxt   = hit_cnt;
    miss_nxt  = miss_cnt;
    slip_nxt  = 1'b0;
    case (state)
      SEARCH: begin
        if (is_hit) begin
          if (LOCK_CNT == 1) begin
            state_nxt = LOCK;
            miss_nxt  = '0;
          end else begin
            state_nxt = VERIFY;
            hit_nxt   = HIT_W'(1);
          end
        end else begin
          slip_nxt = 1'b1;
        end
      end
      VERIFY: begin
        if (is_hit) begin
          hit_nxt = hit_cnt + HIT_W'(1);
          if (hit_nxt == HIT_W'(LOCK_CNT)) begin
            state_nxt = LOCK;
            miss_nxt  = '0;
          end
        end else begin
          state_nxt = SEARCH;
          hit_nxt   = '0;
          slip_nxt  = 1'b1;
        end
      end
      LOCK: begin
        if (is_hit) begin
          miss_nxt = '0;
        end else begin
          miss_nxt = miss_cnt + MISS_W'(1);
          if (miss_nxt == MISS_W'(MISS_CNT)) begin
            state_nxt = SEARCH;
            hit_nxt   = '0;
            miss_nxt  = '0;
            slip_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SEARCH;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (eval) begin
      state    <= state_nxt;
      hit_cnt  <= hit_nxt;
      miss_cnt <= miss_nxt;
    end
  end

  // Dump at T latches s_I/s_Q, evaluation at T+1 updates outputs, result_ok fires at T+2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_I     <= '0;
      acc_Q     <= '0;
      chip_cnt  <= '0;
      s_I       <= '0;
      s_Q       <= '0;
      dump_d    <= 1'b0;
      rdy_d     <= 1'b0;
      sum_I     <= '0;
      sum_Q     <= '0;
      flag      <= 1'b0;
      slip      <= 1'b0;
      result_ok <= 1'b0;
    end else begin
      dump_d    <= 1'b0;
      rdy_d     <= 1'b0;
      slip      <= 1'b0;
      result_ok <= rdy_d;
      if (!en) begin
        acc_I    <= '0;
        acc_Q    <= '0;
        chip_cnt <= '0;
      end else if (chip_vld) begin
        if (chip_cnt == CNT_W'(CHIPS_PER_SYM - 1)) begin
          s_I      <= acc_I_nxt;
          s_Q      <= acc_Q_nxt;
          acc_I    <= '0;
          acc_Q    <= '0;
          chip_cnt <= '0;
          dump_d   <= 1'b1;
        end else begin
          acc_I    <= acc_I_nxt;
          acc_Q    <= acc_Q_nxt;
          chip_cnt <= chip_cnt + CNT_W'(1);
        end
      end
      if (eval) begin
        sum_I <= s_I;
        sum_Q <= s_Q;
        flag  <= (state_nxt == LOCK);
        slip  <= slip_nxt;
        rdy_d <= 1'b1;
      end
    end
  end

endmodule
